// File: rtl/j11mem_if.sv
// j11mem_if: bundles the bridge-side memory request bus and the peripheral
// register bus of the J11 memory responder.
//   memreq/memwr/memaddr/memwdata/memwstrb : request from the bus bridge
//   memack/memrdata/memerr                 : one-cycle completion back to it
//   iopreq/iopwr/iopaddr/iopwdata/iopwstrb : IO page request to peripherals
//   iopack/ioprdata/ioperr                 : IO page completion
// Modports: slave = the j11mem responder, master = its environment.
interface j11mem_if;
  logic        memreq;
  logic        memwr;
  logic [21:0] memaddr;
  logic [15:0] memwdata;
  logic [1:0]  memwstrb;
  logic        memack;
  logic [15:0] memrdata;
  logic        memerr;
  logic        iopreq;
  logic        iopwr;
  logic [12:0] iopaddr;
  logic [15:0] iopwdata;
  logic [1:0]  iopwstrb;
  logic        iopack;
  logic [15:0] ioprdata;
  logic        ioperr;

  modport slave (
    input  memreq, memwr, memaddr, memwdata, memwstrb,
    output memack, memrdata, memerr,
    output iopreq, iopwr, iopaddr, iopwdata, iopwstrb,
    input  iopack, ioprdata, ioperr
  );

  modport master (
    output memreq, memwr, memaddr, memwdata, memwstrb,
    input  memack, memrdata, memerr,
    input  iopreq, iopwr, iopaddr, iopwdata, iopwstrb,
    output iopack, ioprdata, ioperr
  );
endinterface

// File: rtl/j11mem.sv
// j11mem: memory-side responder for the J11 bus bridge.
// Decodes each accepted memreq into local byte-strobed RAM, the IO page
// (top 8 KB, forwarded over the iopreq/iopack bus) or nonexistent memory,
// and returns exactly one memack pulse with read data and an error flag.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : j11mem_if.slave (memory request side and IO page side)
// Parameters:
//   RAMBITS : log2 of RAM size in 16-bit words (10..20)
//   TIMEOUT : cycles to wait for iopack before flagging a bus error
// Build option:
//   J11MEM_NXM_EN defined   -> non-IO addresses above the RAM are NXM errors.
//   J11MEM_NXM_EN undefined -> every non-IO address aliases into the RAM.
module j11mem #(
  parameter int RAMBITS = 17,
  parameter int TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rstn,
  j11mem_if.slave  bus
);

  localparam int          RAM_WORDS = 1 << RAMBITS;
  localparam logic [15:0] TO_LOAD   = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RAMRD, IOWAIT, ACK} state_t;

  state_t state_q, state_d;

  logic               memack_q, memack_d;
  logic               memerr_q, memerr_d;
  logic [15:0]        memrdata_q, memrdata_d;
  logic               iopreq_q, iopreq_d;
  logic               iopwr_q, iopwr_d;
  logic [12:0]        iopaddr_q, iopaddr_d;
  logic [15:0]        iopwdata_q, iopwdata_d;
  logic [1:0]         iopwstrb_q, iopwstrb_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               nxm_q, nxm_d;

  logic               is_iop, is_ram, ram_en;
  logic [1:0]         ram_we;
  logic [RAMBITS-1:0] ram_idx;

  logic [7:0]         ram_lo_q [RAM_WORDS];
  logic [7:0]         ram_hi_q [RAM_WORDS];
  logic [15:0]        ram_rdata_q;

  // Address decode of the incoming request.
  always_comb begin
    is_iop  = (bus.memaddr[21:13] == 9'h1FF);
`ifdef J11MEM_NXM_EN
    is_ram  = !is_iop && (bus.memaddr[21:RAMBITS+1] == '0);
`else
    is_ram  = !is_iop;
`endif
    ram_idx = bus.memaddr[RAMBITS:1];
    ram_en  = (state_q == IDLE) && bus.memreq && is_ram;
    ram_we  = (ram_en && bus.memwr) ? bus.memwstrb : 2'b00;
  end

  // RAM is accessed on the request edge itself; the read is read-before-write
  // so a write ack carries the word's previous contents.
  always_ff @(posedge clk) begin
    if (ram_en) begin
      ram_rdata_q <= {ram_hi_q[ram_idx], ram_lo_q[ram_idx]};
      if (ram_we[0]) ram_lo_q[ram_idx] <= bus.memwdata[7:0];
      if (ram_we[1]) ram_hi_q[ram_idx] <= bus.memwdata[15:8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. NXM shares the RAMRD slot so its ack lands on the
  // same cycle as a RAM ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.memreq) state_d = is_iop ? IOWAIT : RAMRD;
      RAMRD:   state_d = ACK;
      IOWAIT:  if (bus.iopack || (cnt_q == '0)) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    memack_d   = 1'b0;
    memerr_d   = 1'b0;
    memrdata_d = '0;
    iopreq_d   = 1'b0;
    iopwr_d    = iopwr_q;
    iopaddr_d  = iopaddr_q;
    iopwdata_d = iopwdata_q;
    iopwstrb_d = iopwstrb_q;
    cnt_d      = cnt_q;
    nxm_d      = nxm_q;
    case (state_q)
      IDLE: begin
        if (bus.memreq) begin
          nxm_d = !is_iop && !is_ram;
          if (is_iop) begin
            iopreq_d   = 1'b1;
            iopwr_d    = bus.memwr;
            iopaddr_d  = bus.memaddr[12:0];
            iopwdata_d = bus.memwdata;
            iopwstrb_d = bus.memwstrb;
            cnt_d      = TO_LOAD;
          end
        end
      end
      RAMRD: begin
        memack_d   = 1'b1;
        memerr_d   = nxm_q;
        memrdata_d = nxm_q ? 16'h0000 : ram_rdata_q;
      end
      IOWAIT: begin
        // An iopack on the expiry cycle still completes normally.
        if (bus.iopack) begin
          memack_d   = 1'b1;
          memerr_d   = bus.ioperr;
          memrdata_d = bus.ioprdata;
        end else if (cnt_q == '0) begin
          memack_d   = 1'b1;
          memerr_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      memack_q   <= 1'b0;
      memerr_q   <= 1'b0;
      memrdata_q <= '0;
      iopreq_q   <= 1'b0;
      iopwr_q    <= 1'b0;
      iopaddr_q  <= '0;
      iopwdata_q <= '0;
      iopwstrb_q <= '0;
      cnt_q      <= '0;
      nxm_q      <= 1'b0;
    end else begin
      memack_q   <= memack_d;
      memerr_q   <= memerr_d;
      memrdata_q <= memrdata_d;
      iopreq_q   <= iopreq_d;
      iopwr_q    <= iopwr_d;
      iopaddr_q  <= iopaddr_d;
      iopwdata_q <= iopwdata_d;
      iopwstrb_q <= iopwstrb_d;
      cnt_q      <= cnt_d;
      nxm_q      <= nxm_d;
    end
  end

  assign bus.memack   = memack_q;
  assign bus.memerr   = memerr_q;
  assign bus.memrdata = memrdata_q;
  assign bus.iopreq   = iopreq_q;
  assign bus.iopwr    = iopwr_q;
  assign bus.iopaddr  = iopaddr_q;
  assign bus.iopwdata = iopwdata_q;
  assign bus.iopwstrb = iopwstrb_q;

endmodule
